// File: rtl/clkdiv_multi.sv
// -----------------------------------------------------------------------------
// clkdiv_multi
//
// Multi-channel programmable clock divider. Each of CHANNELS channels divides
// clk by its own integer divisor. Each channel drives a registered clock output
// and a one-cycle tick strobe. Use the strobe as a clock enable in the clk
// domain. A new divisor goes to a shadow register first. It becomes active
// only at a period boundary, which is a wrap or a sync. The period in
// progress always completes with the old divisor, so the output never glitches.
//
// Waveform for divisor D: clk_out is high for D - floor(D/2) cycles, then low
// for floor(D/2) cycles. The tick pulse falls on the first high cycle.
//
// Ports:
//   clk      in   system clock
//   rst      in   asynchronous, active-high reset
//   en       in   [CHANNELS]  per-channel run enable (0 freezes the channel)
//   sync     in   restart the phase of all channels together
//   wr_en    in   divisor write strobe
//   wr_ch    in   [CH_W]      channel addressed by the write (>= CHANNELS ignored)
//   wr_div   in   [CNT_W]     new divisor (0 and 1 are clamped to 2)
//   clk_out  out  [CHANNELS]  registered divided clocks
//   tick     out  [CHANNELS]  one-cycle pulse at the start of each high phase
//   pending  out  [CHANNELS]  a written divisor is waiting to be applied
// -----------------------------------------------------------------------------
module clkdiv_multi #(
   parameter int CHANNELS  = 4,
   parameter int CNT_W     = 16,
   parameter int RESET_DIV = 4,
   parameter int CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [CHANNELS-1:0] en,
   input  logic                sync,
   input  logic                wr_en,
   input  logic [CH_W-1:0]     wr_ch,
   input  logic [CNT_W-1:0]    wr_div,
   output logic [CHANNELS-1:0] clk_out,
   output logic [CHANNELS-1:0] tick,
   output logic [CHANNELS-1:0] pending
);

   localparam logic [CNT_W-1:0] RESET_D = CNT_W'(RESET_DIV);
   localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
   localparam logic [CNT_W-1:0] TWO     = CNT_W'(2);

   // Per-channel state: active divisor, shadow divisor, phase counter.
   logic [CNT_W-1:0]    div_q    [CHANNELS];
   logic [CNT_W-1:0]    div_d    [CHANNELS];
   logic [CNT_W-1:0]    shadow_q [CHANNELS];
   logic [CNT_W-1:0]    shadow_d [CHANNELS];
   logic [CNT_W-1:0]    cnt_q    [CHANNELS];
   logic [CNT_W-1:0]    cnt_d    [CHANNELS];

   logic [CHANNELS-1:0] clk_out_q, clk_out_d;
   logic [CHANNELS-1:0] tick_q,    tick_d;
   logic [CHANNELS-1:0] pending_q, pending_d;

   logic                wr_valid;
   logic [CNT_W-1:0]    wr_div_clamped;

   // Write decode. Divisors below 2 cannot form a high and a low phase, so
   // they are raised to 2.
   always_comb begin
      wr_valid       = wr_en && (int'(wr_ch) < CHANNELS);
      wr_div_clamped = (wr_div < TWO) ? TWO : wr_div;
   end

   always_comb begin
      logic [CNT_W-1:0] hi;
      logic [CNT_W-1:0] div_next;
      logic             wrap;
      logic             apply;

      hi       = '0;
      div_next = '0;
      wrap     = 1'b0;
      apply    = 1'b0;

      for (int i = 0; i < CHANNELS; i++) begin
         // NOTE: every combinational output gets a default before any branch,
         // so no path through the block can leave it unassigned (no latch).
         div_d[i]     = div_q[i];
         shadow_d[i]  = shadow_q[i];
         cnt_d[i]     = cnt_q[i];
         clk_out_d[i] = clk_out_q[i];
         tick_d[i]    = 1'b0;
         pending_d[i] = pending_q[i];

         hi       = div_q[i] - (div_q[i] >> 1);
         wrap     = (cnt_q[i] == div_q[i] - ONE);
         // Divisor that governs the period about to start.
         div_next = pending_q[i] ? shadow_q[i] : div_q[i];
         // A pending divisor is applied only at a period boundary.
         apply    = pending_q[i] && (sync || (en[i] && wrap));

         if (apply) begin
            div_d[i]     = shadow_q[i];
            pending_d[i] = 1'b0;
         end

         if (sync && !en[i]) begin
            // Park on the last count so the first enabled edge starts a
            // fresh period, aligned with the channels that were running.
            cnt_d[i]     = div_next - ONE;
            clk_out_d[i] = 1'b0;
         end else if (en[i] && (sync || wrap)) begin
            cnt_d[i]     = '0;
            clk_out_d[i] = 1'b1;
            tick_d[i]    = 1'b1;
         end else if (en[i]) begin
            cnt_d[i]     = cnt_q[i] + ONE;
            clk_out_d[i] = (cnt_q[i] + ONE) < hi;
         end

         // A write lands after the apply. A write in the same cycle as an
         // apply therefore stays pending for the following boundary.
         if (wr_valid && (wr_ch == CH_W'(i))) begin
            shadow_d[i]  = wr_div_clamped;
            pending_d[i] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: the per-channel arrays are ordinary flops, not a RAM, so they
         // are reset along with the rest of the state.
         for (int i = 0; i < CHANNELS; i++) begin
            div_q[i]    <= RESET_D;
            shadow_q[i] <= RESET_D;
            cnt_q[i]    <= RESET_D - ONE;
         end
         clk_out_q <= '0;
         tick_q    <= '0;
         pending_q <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments, so every flop
         // samples the values from before the edge.
         for (int i = 0; i < CHANNELS; i++) begin
            div_q[i]    <= div_d[i];
            shadow_q[i] <= shadow_d[i];
            cnt_q[i]    <= cnt_d[i];
         end
         clk_out_q <= clk_out_d;
         tick_q    <= tick_d;
         pending_q <= pending_d;
      end
   end

   assign clk_out = clk_out_q;
   assign tick    = tick_q;
   assign pending = pending_q;

endmodule

// File: tb/tb_clkdiv_multi.sv
// -----------------------------------------------------------------------------
// tb_clkdiv_multi
//
// Bench for clkdiv_multi with 4 channels, a 16-bit counter and a reset
// divisor of 4. It has three parts:
//   - A vector table covering reset release and a mid-period divisor write.
//   - Hand-written sequences for the multi-cycle corner cases.
//   - Randomised traffic.
// A behavioural model follows every cycle. It tracks each channel as a
// position within its period, and derives the expected clock level from the
// high-phase length.
// -----------------------------------------------------------------------------
module tb_clkdiv_multi;

   localparam int CHANNELS  = 4;
   localparam int CNT_W     = 16;
   localparam int RESET_DIV = 4;
   localparam int CH_W      = 2;

   logic                clk = 1'b0;
   logic                rst;
   logic [CHANNELS-1:0] en;
   logic                sync;
   logic                wr_en;
   logic [CH_W-1:0]     wr_ch;
   logic [CNT_W-1:0]    wr_div;
   logic [CHANNELS-1:0] clk_out;
   logic [CHANNELS-1:0] tick;
   logic [CHANNELS-1:0] pending;

   clkdiv_multi #(
      .CHANNELS (CHANNELS),
      .CNT_W    (CNT_W),
      .RESET_DIV(RESET_DIV)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .en     (en),
      .sync   (sync),
      .wr_en  (wr_en),
      .wr_ch  (wr_ch),
      .wr_div (wr_div),
      .clk_out(clk_out),
      .tick   (tick),
      .pending(pending)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // Behavioural model: divisor, shadow, position within period, pending.
   int m_d    [CHANNELS];
   int m_s    [CHANNELS];
   int m_pos  [CHANNELS];
   bit m_pend [CHANNELS];
   bit m_tick [CHANNELS];

   typedef struct {
      logic [CHANNELS-1:0] en;
      logic                sync;
      logic                wr_en;
      logic [CH_W-1:0]     wr_ch;
      logic [CNT_W-1:0]    wr_div;
      logic [CHANNELS-1:0] exp_clk;
      logic [CHANNELS-1:0] exp_tick;
      logic [CHANNELS-1:0] exp_pend;
   } vec_t;

   vec_t vecs[12];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [CHANNELS-1:0] m_clk_vec();
      logic [CHANNELS-1:0] v;
      v = '0;
      for (int i = 0; i < CHANNELS; i++) v[i] = (m_pos[i] < (m_d[i] - m_d[i] / 2));
      return v;
   endfunction

   function automatic logic [CHANNELS-1:0] m_tick_vec();
      logic [CHANNELS-1:0] v;
      v = '0;
      for (int i = 0; i < CHANNELS; i++) v[i] = m_tick[i];
      return v;
   endfunction

   function automatic logic [CHANNELS-1:0] m_pend_vec();
      logic [CHANNELS-1:0] v;
      v = '0;
      for (int i = 0; i < CHANNELS; i++) v[i] = m_pend[i];
      return v;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < CHANNELS; i++) begin
         m_d[i]    = RESET_DIV;
         m_s[i]    = RESET_DIV;
         m_pos[i]  = RESET_DIV - 1;
         m_pend[i] = 1'b0;
         m_tick[i] = 1'b0;
      end
   endtask

   // One clk edge of the model, driven by the inputs presented at that edge.
   task automatic model_step();
      for (int i = 0; i < CHANNELS; i++) begin
         bit start;
         start = sync ? en[i] : (en[i] && (m_pos[i] == m_d[i] - 1));
         if (m_pend[i] && (sync || start)) begin
            m_d[i]    = m_s[i];
            m_pend[i] = 1'b0;
         end
         if (sync && !en[i]) m_pos[i] = m_d[i] - 1;
         else if (start)     m_pos[i] = 0;
         else if (en[i])     m_pos[i] = m_pos[i] + 1;
         m_tick[i] = start;
         if (wr_en && (int'(wr_ch) == i)) begin
            m_s[i]    = (wr_div < 2) ? 2 : int'(wr_div);
            m_pend[i] = 1'b1;
         end
      end
   endtask

   // Advance one edge and compare every output with the model.
   task automatic cycle(input string tag);
      @(posedge clk);
      model_step();
      #1;
      check($sformatf("%s clk_out", tag), clk_out, m_clk_vec());
      check($sformatf("%s tick", tag),    tick,    m_tick_vec());
      check($sformatf("%s pending", tag), pending, m_pend_vec());
   endtask

   task automatic idle_inputs();
      sync   = 1'b0;
      wr_en  = 1'b0;
      wr_ch  = '0;
      wr_div = '0;
   endtask

   // Count edges from now up to and including the next tick on channel ch.
   task automatic tick_gap(input int ch, input string tag, output int gap);
      gap = 0;
      do begin
         cycle(tag);
         gap++;
      end while (!tick[ch] && gap < 50);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int gap;
      int budget;

      // Reset release with all channels enabled, then a ch1 write of 5 at cnt=1.
      //             en     sy  we  ch  div    clk    tick   pend
      vecs[0]  = '{4'hF, 1'b0, 1'b0, 2'd0, 16'd0, 4'hF, 4'hF, 4'h0};
      vecs[1]  = '{4'hF, 1'b0, 1'b0, 2'd0, 16'd0, 4'hF, 4'h0, 4'h0};
      vecs[2]  = '{4'hF, 1'b0, 1'b1, 2'd1, 16'd5, 4'h0, 4'h0, 4'h2};
      vecs[3]  = '{4'hF, 1'b0, 1'b0, 2'd0, 16'd0, 4'h0, 4'h0, 4'h2};
      vecs[4]  = '{4'hF, 1'b0, 1'b0, 2'd0, 16'd0, 4'hF, 4'hF, 4'h0};
      vecs[5]  = '{4'hF, 1'b0, 1'b0, 2'd0, 16'd0, 4'hF, 4'h0, 4'h0};
      vecs[6]  = '{4'hF, 1'b0, 1'b0, 2'd0, 16'd0, 4'h2, 4'h0, 4'h0};
      vecs[7]  = '{4'hF, 1'b0, 1'b0, 2'd0, 16'd0, 4'h0, 4'h0, 4'h0};
      vecs[8]  = '{4'hF, 1'b0, 1'b0, 2'd0, 16'd0, 4'hD, 4'hD, 4'h0};
      vecs[9]  = '{4'hF, 1'b0, 1'b0, 2'd0, 16'd0, 4'hF, 4'h2, 4'h0};
      vecs[10] = '{4'hF, 1'b0, 1'b0, 2'd0, 16'd0, 4'h2, 4'h0, 4'h0};
      vecs[11] = '{4'hF, 1'b0, 1'b0, 2'd0, 16'd0, 4'h2, 4'h0, 4'h0};

      rst = 1'b1;
      en  = 4'hF;
      idle_inputs();
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("reset clk_out", clk_out, 4'h0);
      check("reset tick",    tick,    4'h0);
      check("reset pending", pending, 4'h0);
      @(negedge clk);
      rst = 1'b0;

      foreach (vecs[v]) begin
         en     = vecs[v].en;
         sync   = vecs[v].sync;
         wr_en  = vecs[v].wr_en;
         wr_ch  = vecs[v].wr_ch;
         wr_div = vecs[v].wr_div;
         cycle($sformatf("vec%0d model", v));
         check($sformatf("vec%0d clk_out", v), clk_out, vecs[v].exp_clk);
         check($sformatf("vec%0d tick", v),    tick,    vecs[v].exp_tick);
         check($sformatf("vec%0d pending", v), pending, vecs[v].exp_pend);
      end
      idle_inputs();

      // ch2: writes of 0 then 1 back to back settle on D=2 with a toggling output.
      wr_en = 1'b1; wr_ch = 2'd2; wr_div = 16'd0;
      cycle("ch2 wr0");
      wr_div = 16'd1;
      cycle("ch2 wr1");
      idle_inputs();
      check("ch2 pending after writes", pending[2], 1'b1);
      budget = 0;
      while (pending[2] && budget < 20) begin
         cycle("ch2 wait");
         budget++;
      end
      check("ch2 apply within budget", pending[2], 1'b0);
      check("ch2 tick on apply", tick[2], 1'b1);
      for (int k = 0; k < 4; k++) begin
         cycle("ch2 toggle");
         check($sformatf("ch2 toggle clk%0d", k), clk_out[2], (k % 2) == 1);
         check($sformatf("ch2 toggle tick%0d", k), tick[2], (k % 2) == 1);
      end

      // ch0: a write on the wrap edge waits one full old period.
      budget = 0;
      while (!(m_pos[0] == m_d[0] - 1) && budget < 20) begin
         cycle("ch0 seek wrap");
         budget++;
      end
      check("ch0 wrap found", m_pos[0] == m_d[0] - 1, 1'b1);
      wr_en = 1'b1; wr_ch = 2'd0; wr_div = 16'd6;
      cycle("ch0 wr on wrap");
      idle_inputs();
      check("ch0 tick on write edge", tick[0], 1'b1);
      check("ch0 pending after wrap write", pending[0], 1'b1);
      tick_gap(0, "ch0 gap1", gap);
      check("ch0 old period length", gap, 4);
      check("ch0 pending cleared at wrap", pending[0], 1'b0);
      tick_gap(0, "ch0 gap2", gap);
      check("ch0 new period length", gap, 6);
      tick_gap(0, "ch0 gap3", gap);
      check("ch0 steady period length", gap, 6);

      // Divisors 3,4,5,7, then a sync with ch3 disabled.
      for (int c = 0; c < CHANNELS; c++) begin
         wr_en = 1'b1; wr_ch = CH_W'(c);
         case (c)
            0:       wr_div = 16'd3;
            1:       wr_div = 16'd4;
            2:       wr_div = 16'd5;
            default: wr_div = 16'd7;
         endcase
         cycle("multi wr");
      end
      idle_inputs();
      budget = 0;
      while (pending != 4'h0 && budget < 40) begin
         cycle("multi wait");
         budget++;
      end
      check("multi all applied", pending, 4'h0);
      repeat (11) cycle("multi run");
      en = 4'b0111; sync = 1'b1;
      cycle("sync");
      sync = 1'b0;
      check("sync tick", tick, 4'b0111);
      check("sync clk_out", clk_out, 4'b0111);
      for (int k = 0; k < 3; k++) begin
         cycle("sync hold");
         check($sformatf("ch3 parked clk%0d", k), clk_out[3], 1'b0);
      end
      en = 4'hF;
      cycle("ch3 enable");
      check("ch3 first enabled tick", tick[3], 1'b1);
      check("ch3 first enabled clk", clk_out[3], 1'b1);

      // ch3 frozen in its high phase, then resumes.
      en = 4'b0111;
      for (int k = 0; k < 4; k++) begin
         cycle("ch3 frozen");
         check($sformatf("ch3 frozen clk%0d", k), clk_out[3], 1'b1);
         check($sformatf("ch3 frozen tick%0d", k), tick[3], 1'b0);
      end
      en = 4'hF;
      repeat (10) cycle("ch3 resume");

      // A pending write followed by reset mid-period is discarded.
      wr_en = 1'b1; wr_ch = 2'd0; wr_div = 16'd9;
      cycle("pre-reset wr");
      idle_inputs();
      check("pre-reset pending", pending[0], 1'b1);
      #2;
      rst = 1'b1;
      #1;
      check("async reset clk_out", clk_out, 4'h0);
      check("async reset tick",    tick,    4'h0);
      check("async reset pending", pending, 4'h0);
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 8; k++) begin
         cycle("post-reset");
         check($sformatf("post-reset ch0 clk%0d", k), clk_out[0], (k % 4) < 2);
         check($sformatf("post-reset ch0 pend%0d", k), pending[0], 1'b0);
      end

      // Randomised traffic against the model.
      for (int n = 0; n < 3000; n++) begin
         for (int i = 0; i < CHANNELS; i++) en[i] = ($urandom_range(0, 9) != 0);
         sync   = ($urandom_range(0, 99) < 3);
         wr_en  = ($urandom_range(0, 99) < 15);
         wr_ch  = CH_W'($urandom_range(0, CHANNELS - 1));
         wr_div = ($urandom_range(0, 9) < 7) ? CNT_W'($urandom_range(0, 9))
                                             : CNT_W'($urandom_range(0, 40));
         cycle("random");
      end
      idle_inputs();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
